// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: four-phase command sequencer driving an external combinational ALU from a register file and PSR
module alu_cmd_sequencer #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_rdest,
    input  logic [REG_ADDR_W-1:0] cmd_rsrc,
    input  logic [15:0]           cmd_imm,
    input  logic                  cmd_use_imm,
    output logic [15:0]           alu_input1,
    output logic [15:0]           alu_input2,
    output logic [4:0]            alu_op,
    output logic [4:0]            alu_inflags,
    input  logic [15:0]           alu_result,
    input  logic [4:0]            alu_outflags,
    output logic [4:0]            psr,
    output logic                  done,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [15:0]           dbg_data
);
    localparam int NREG = 1 << REG_ADDR_W;
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    state_t state, state_nxt;
    logic [15:0] rf [NREG];
    logic [4:0] op_q;
    logic [REG_ADDR_W-1:0] rdest_q, rsrc_q;
    logic [15:0] imm_q, res_q, wb_data;
    logic use_imm_q;
    logic [4:0] flags_q;
    logic rf_we, psr_we;
    always_comb begin
        state_nxt = state == IDLE ? (cmd_valid ? READ : IDLE) :
                    state == READ ? EXEC :
                    state == EXEC ? WB : IDLE;
        cmd_ready = reset && state == IDLE;
        done = state == WB;
        rf_we = done && ((op_q >= 5'd1 && op_q <= 5'd5) || (op_q >= 5'd8 && op_q <= 5'd16));
        psr_we = done && op_q >= 5'd1 && op_q <= 5'd7;
        wb_data = op_q == 5'd16 ? imm_q : res_q;
    end
    assign dbg_data = rf[dbg_addr];
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            psr <= '0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_op <= '0;
            alu_inflags <= '0;
            op_q <= '0;
            rdest_q <= '0;
            rsrc_q <= '0;
            imm_q <= '0;
            use_imm_q <= 1'b0;
            res_q <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q <= cmd_op;
                rdest_q <= cmd_rdest;
                rsrc_q <= cmd_rsrc;
                imm_q <= cmd_imm;
                use_imm_q <= cmd_use_imm;
            end
            if (state == READ) begin
                alu_input1 <= rf[rdest_q];
                alu_input2 <= use_imm_q ? imm_q : rf[rsrc_q];
                alu_op <= op_q;
                alu_inflags <= psr;
            end
            if (state == EXEC) begin
                res_q <= alu_result;
                flags_q <= alu_outflags;
            end
            // dbg_data sees the old value throughout WB; the write lands at its closing edge
            if (rf_we)
                rf[rdest_q] <= wb_data;
            if (psr_we)
                psr <= flags_q;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed scoreboard bench with a behavioural 16-bit ALU on the alu_* ports
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic reset, cmd_valid, cmd_ready, cmd_use_imm, done;
    logic [4:0] cmd_op, alu_op, alu_inflags, alu_outflags, psr;
    logic [3:0] cmd_rdest, cmd_rsrc, dbg_addr;
    logic [15:0] cmd_imm, alu_input1, alu_input2, alu_result, dbg_data;

    alu_cmd_sequencer #(.REG_ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rdest(cmd_rdest), .cmd_rsrc(cmd_rsrc), .cmd_imm(cmd_imm),
        .cmd_use_imm(cmd_use_imm), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_op(alu_op), .alu_inflags(alu_inflags), .alu_result(alu_result),
        .alu_outflags(alu_outflags), .psr(psr), .done(done), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: flags are {N, Z, F, L, C}
    logic [16:0] sum;
    logic [15:0] r;
    logic c, l, f;
    always_comb begin
        sum = '0;
        r = '0;
        c = 1'b0;
        l = 1'b0;
        f = 1'b0;
        case (alu_op)
            5'd1, 5'd2: sum = {1'b0, alu_input1} + {1'b0, alu_input2};
            5'd3, 5'd4: sum = {1'b0, alu_input1} + {1'b0, alu_input2} + {16'd0, alu_inflags[0]};
            5'd5, 5'd6, 5'd7: sum = {1'b0, alu_input1} - {1'b0, alu_input2};
            default: sum = '0;
        endcase
        case (alu_op)
            5'd8: r = alu_input1 & alu_input2;
            5'd9: r = alu_input1 | alu_input2;
            5'd10: r = alu_input1 ^ alu_input2;
            5'd11: r = ~alu_input1;
            5'd12, 5'd14: r = alu_input1 << 1;
            5'd13: r = alu_input1 >> 1;
            5'd15: r = 16'($signed(alu_input1) >>> 1);
            default: r = sum[15:0];
        endcase
        if (alu_op >= 5'd1 && alu_op <= 5'd4) begin
            c = sum[16];
            f = (alu_input1[15] == alu_input2[15]) && (r[15] != alu_input1[15]);
        end
        if (alu_op >= 5'd5 && alu_op <= 5'd7) begin
            c = sum[16];
            l = alu_input1 < alu_input2;
            f = (alu_input1[15] != alu_input2[15]) && (r[15] != alu_input1[15]);
        end
    end
    assign alu_result = r;
    assign alu_outflags = {r[15], r == 16'd0, f, l, c};

    typedef struct {
        string tag;
        logic [3:0] rd;
        logic [15:0] val;
        logic [4:0] psr;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit pend = 0;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int accs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: retire the pending register/PSR check, then pop on a done pulse
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pend) begin
            chk({cur.tag, " reg"}, 32'(dbg_data), 32'(cur.val));
            chk({cur.tag, " psr"}, 32'(psr), 32'(cur.psr));
            pend = 0;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious done", 32'(done), 32'd0);
            end else begin
                cur = sb.pop_front();
                chk({cur.tag, " latency"}, 32'(cyc - cur.acc), 32'd3);
                dbg_addr = cur.rd;
                pend = 1;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || pend) && n < 20) begin
            step();
            n++;
        end
        chk({tag, " retire"}, 32'(sb.size()) + 32'(pend), 32'd0);
    endtask

    task automatic issue(input string tag, input logic [4:0] op, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [15:0] imm, input logic ui,
                         input logic [15:0] ev, input logic [4:0] ep);
        int n = 0;
        cmd_op = op;
        cmd_rdest = rd;
        cmd_rsrc = rs;
        cmd_imm = imm;
        cmd_use_imm = ui;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 10) begin
            step();
            n++;
        end
        chk({tag, " accept"}, 32'(cmd_ready), 32'd1);
        sb.push_back('{tag, rd, ev, ep, cyc});
        step();
        cmd_valid = 1'b0;
        cmd_op = 5'd16;
        cmd_rdest = rd ^ 4'd1;
        cmd_rsrc = rs ^ 4'd1;
        cmd_imm = 16'hdead;
        cmd_use_imm = ~ui;
        drain(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_rdest = '0;
        cmd_rsrc = '0;
        cmd_imm = '0;
        cmd_use_imm = 1'b0;
        dbg_addr = '0;
        repeat (3) step();
        chk("ready in reset", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        step();
        chk("ready after reset", 32'(cmd_ready), 32'd1);
        chk("psr after reset", 32'(psr), 32'd0);
        chk("r0 after reset", 32'(dbg_data), 32'd0);

        issue("movi r1", 5'd16, 4'd1, 4'd0, 16'd4, 1'b1, 16'd4, 5'd0);
        issue("movi r2", 5'd16, 4'd2, 4'd0, 16'd17, 1'b1, 16'd17, 5'd0);
        issue("add r1,r2", 5'd1, 4'd1, 4'd2, 16'd0, 1'b0, 16'd21, 5'd0);

        issue("movi r3", 5'd16, 4'd3, 4'd0, 16'hffff, 1'b1, 16'hffff, 5'd0);
        issue("addu r3", 5'd2, 4'd3, 4'd0, 16'd1, 1'b1, 16'd0, 5'b01001);
        issue("addc r3", 5'd3, 4'd3, 4'd0, 16'd0, 1'b1, 16'd1, 5'b00000);
        chk("addc inflags", 32'(alu_inflags[0]), 32'd1);

        issue("movi r4", 5'd16, 4'd4, 4'd0, 16'd17, 1'b1, 16'd17, 5'd0);
        issue("cmp r4", 5'd6, 4'd4, 4'd0, 16'd17, 1'b1, 16'd17, 5'b01000);
        issue("and r4", 5'd8, 4'd4, 4'd0, 16'd5, 1'b1, 16'd1, 5'b01000);

        // Valid held high while the command changes every cycle
        for (int i = 0; i < 9; i++) begin
            cmd_op = 5'd16;
            cmd_rdest = 4'(6 + i);
            cmd_imm = 16'(100 + i);
            cmd_use_imm = 1'b1;
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                sb.push_back('{"b2b", 4'(6 + i), 16'(100 + i), 5'b01000, cyc});
                accs.push_back(cyc);
            end
            step();
        end
        cmd_valid = 1'b0;
        drain("b2b");
        chk("b2b accepts", 32'(accs.size()), 32'd3);
        if (accs.size() == 3) begin
            chk("b2b gap1", 32'(accs[1] - accs[0]), 32'd4);
            chk("b2b gap2", 32'(accs[2] - accs[1]), 32'd4);
        end
        dbg_addr = 4'd7;
        #1 chk("b2b r7 skipped", 32'(dbg_data), 32'd0);
        dbg_addr = 4'd13;
        #1 chk("b2b r13 skipped", 32'(dbg_data), 32'd0);

        // Reset during EXEC of an ADD into r1
        cmd_op = 5'd1;
        cmd_rdest = 4'd1;
        cmd_rsrc = 4'd2;
        cmd_use_imm = 1'b0;
        cmd_valid = 1'b1;
        chk("abort accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        step();
        chk("abort in exec input1", 32'(alu_input1), 32'd21);
        reset = 1'b0;
        step();
        chk("abort done", 32'(done), 32'd0);
        chk("abort ready low", 32'(cmd_ready), 32'd0);
        chk("abort psr", 32'(psr), 32'd0);
        chk("abort alu_input1", 32'(alu_input1), 32'd0);
        chk("abort alu_input2", 32'(alu_input2), 32'd0);
        chk("abort alu_op", 32'(alu_op), 32'd0);
        chk("abort alu_inflags", 32'(alu_inflags), 32'd0);
        dbg_addr = 4'd1;
        #1 chk("abort r1", 32'(dbg_data), 32'd0);
        reset = 1'b1;
        step();
        chk("abort ready after release", 32'(cmd_ready), 32'd1);
        repeat (4) step();
        chk("abort r1 stays", 32'(dbg_data), 32'd0);

        issue("movi r5", 5'd16, 4'd5, 4'd0, 16'd69, 1'b1, 16'd69, 5'd0);
        issue("lsh r5", 5'd12, 4'd5, 4'd0, 16'd0, 1'b1, 16'd138, 5'd0);
        issue("rsh r5", 5'd13, 4'd5, 4'd0, 16'd0, 1'b1, 16'd69, 5'd0);
        issue("arsh r5", 5'd15, 4'd5, 4'd0, 16'd0, 1'b1, 16'd34, 5'd0);
        issue("nop20", 5'd20, 4'd5, 4'd5, 16'h1234, 1'b1, 16'd34, 5'd0);
        dbg_addr = 4'd4;
        #1 chk("nop r4", 32'(dbg_data), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
